shift_add_multiplier: RTL

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/mult_pkg.sv | 17 +
 rtl/twos_abs.sv | 19 +
 rtl/shift_add_multiplier.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM states, default
// operand width and the iteration-counter width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/twos_abs.sv
// Operand magnitude extraction: converts a possibly two's-complement value into
// an unsigned magnitude of the same width plus a sign bit.
module twos_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_signed_mode,
    output logic [WIDTH-1:0] o_mag,
    output logic             o_sign
);

    logic w_neg;

    assign w_neg  = i_signed_mode & i_value[WIDTH-1];
    assign o_sign = w_neg;
    // The most-negative value negates to 2^(WIDTH-1), which still fits unsigned.
    assign o_mag  = w_neg ? (~i_value + {{(WIDTH-1){1'b0}}, 1'b1}) : i_value;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential sign-magnitude shift-and-add multiplier with a valid/ready
// operand interface and a valid/ready product interface.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int OUT_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH);

    mult_state_t            r_state;
    mult_state_t            w_state_next;
    logic [WIDTH-1:0]       r_mcand;
    logic [WIDTH-1:0]       r_mplier;
    logic                   r_sign;
    logic [2*WIDTH:0]       r_acc;
    logic [CW-1:0]          r_cnt;

    logic [WIDTH-1:0]       w_mag_a;
    logic [WIDTH-1:0]       w_mag_b;
    logic                   w_sign_a;
    logic                   w_sign_b;
    logic [WIDTH:0]         w_addend;
    logic [WIDTH:0]         w_upper;
    logic [2*WIDTH:0]       w_acc_step;
    logic [2*WIDTH-1:0]     w_prod_calc;

    twos_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_value       (a),
        .i_signed_mode (signed_mode),
        .o_mag         (w_mag_a),
        .o_sign        (w_sign_a)
    );

    twos_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_value       (b),
        .i_signed_mode (signed_mode),
        .o_mag         (w_mag_b),
        .o_sign        (w_sign_b)
    );

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = RUN; else w_state_next = IDLE;
            RUN:     if (r_cnt == LAST) w_state_next = DONE; else w_state_next = RUN;
            DONE:    if (out_ready) w_state_next = IDLE; else w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // One iteration: conditionally add into the upper half, then shift right.
    always_comb begin
        w_addend    = r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}};
        w_upper     = r_acc[2*WIDTH:WIDTH] + w_addend;
        w_acc_step  = {1'b0, w_upper, r_acc[WIDTH-1:1]};
        w_prod_calc = r_sign ? (~r_acc[2*WIDTH-1:0] + {{(2*WIDTH-1){1'b0}}, 1'b1})
                             : r_acc[2*WIDTH-1:0];
    end

    // Operand capture and iteration datapath; the counter reaching WIDTH marks
    // the cycle on which the finished accumulator is moved into DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= {WIDTH{1'b0}};
            r_mplier <= {WIDTH{1'b0}};
            r_sign   <= 1'b0;
            r_acc    <= {(2*WIDTH+1){1'b0}};
            r_cnt    <= {CW{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= w_mag_a;
                        r_mplier <= w_mag_b;
                        r_sign   <= w_sign_a ^ w_sign_b;
                        r_acc    <= {(2*WIDTH+1){1'b0}};
                        r_cnt    <= {CW{1'b0}};
                    end
                end
                RUN: begin
                    if (r_cnt != LAST) begin
                        r_acc    <= w_acc_step;
                        r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
                        r_cnt    <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [2*WIDTH-1:0] r_product;

            // Product register: loaded entering DONE, cleared after handoff.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_product <= {(2*WIDTH){1'b0}};
                end else if (r_state == RUN && r_cnt == LAST) begin
                    r_product <= w_prod_calc;
                end else if (r_state == DONE && out_ready) begin
                    r_product <= {(2*WIDTH){1'b0}};
                end else begin
                    r_product <= r_product;
                end
            end

            assign product = r_product;
        end else begin : g_out_comb
            assign product = (r_state == DONE) ? w_prod_calc : {(2*WIDTH){1'b0}};
        end
    endgenerate

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);

endmodule
